// File: rtl/mod4621_svec_reduce_if.sv
// Handshake bus for the mod-4621 partial-residue reducer: input vector in, reduced residue out.
interface mod4621_svec_reduce_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] p0, p1, p2, p3;
  logic [11:0] n0;
  logic [12:0] n1;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] z_out;

  modport master (
    output in_valid, p0, p1, p2, p3, n0, n1, out_ready,
    input  in_ready, out_valid, z_out
  );

  modport slave (
    input  in_valid, p0, p1, p2, p3, n0, n1, out_ready,
    output in_ready, out_valid, z_out
  );
endinterface

// File: rtl/mod4621_svec_reduce.sv
// Two-stage reducer: signed sum of partial residues, then a single-step mod 4621 using
// four parallel threshold compares. Globally stalled by a single pipeline enable.
module mod4621_svec_reduce (
  input  logic                       clk,
  input  logic                       rst_n,
  mod4621_svec_reduce_if.slave       bus
);
  localparam logic [14:0] Q1 = 15'd4621;
  localparam logic [14:0] Q2 = 15'd9242;
  localparam logic [14:0] Q3 = 15'd13863;
  localparam logic [14:0] Q4 = 15'd18484;

  logic        en;
  logic [2:1]  vld_pipe;
  logic [14:0] s1_sum;
  logic [14:0] sub;
  logic [12:0] z_nx;
  logic [12:0] z_q;

  assign en           = !vld_pipe[2] || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = vld_pipe[2];
  assign bus.z_out    = z_q;

  // Adding 2q up front keeps the worst-case negative sum positive, so stage 2 only
  // ever subtracts a non-negative multiple of q.
  always_comb begin
    sub = '0;
    if      (s1_sum >= Q4) sub = Q4;
    else if (s1_sum >= Q3) sub = Q3;
    else if (s1_sum >= Q2) sub = Q2;
    else if (s1_sum >= Q1) sub = Q1;
    z_nx = 13'(s1_sum - sub);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_sum   <= '0;
      z_q      <= '0;
    end else if (en) begin
      vld_pipe[1] <= bus.in_valid;
      vld_pipe[2] <= vld_pipe[1];
      s1_sum      <= 15'(bus.p0) + 15'(bus.p1) + 15'(bus.p2) + 15'(bus.p3) + Q2
                   - 15'(bus.n0) - 15'(bus.n1);
      z_q         <= z_nx;
    end
  end
endmodule

// File: tb/tb_mod4621_svec_reduce.sv
// Randomized bench for the mod-4621 reducer against a signed-sum scoreboard.
module tb_mod4621_svec_reduce;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mod4621_svec_reduce_if bus();
  mod4621_svec_reduce dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int obs_q[$];
  int n_acc   = 0;
  int n_res   = 0;

  function automatic int golden(int a, int b, int c, int d, int e, int f);
    int s;
    s = a + b + c + d - e - f;
    return ((s % 4621) + 4621) % 4621;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input int a, input int b, input int c, input int d,
                       input int e, input int f, input bit v);
    bus.p0 = 12'(a); bus.p1 = 12'(b); bus.p2 = 12'(c); bus.p3 = 12'(d);
    bus.n0 = 12'(e); bus.n1 = 13'(f); bus.in_valid = v;
  endtask

  task automatic rand_vec(input bit v);
    drive($urandom_range(4095), $urandom_range(2046), $urandom_range(3798),
          $urandom_range(2685), $urandom_range(2357), $urandom_range(4158), v);
  endtask

  // Observe handshakes at negedge, let the posedge transfer, return just after it.
  task automatic step();
    @(negedge clk);
    if (bus.out_valid) chk("z_range", bus.z_out < 13'd4621, 1);
    if (bus.out_valid && bus.out_ready) begin
      n_res++;
      obs_q.push_back(int'(bus.z_out));
      chk("pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("data", bus.z_out, exp_q.pop_front());
    end
    if (bus.in_valid && bus.in_ready) begin
      n_acc++;
      exp_q.push_back(golden(bus.p0, bus.p1, bus.p2, bus.p3, bus.n0, bus.n1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int base_res, base_acc, held;
    drive(0, 0, 0, 0, 0, 0, 1'b0);
    bus.out_ready = 1'b1;

    // reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_z_out", bus.z_out, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // zero vector accepted on first edge after release, 2-cycle latency
    drive(0, 0, 0, 0, 0, 0, 1'b1);
    step();
    chk("lat_cyc1_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    step();
    chk("lat_cyc2_valid", bus.out_valid, 1);
    chk("lat_cyc2_z", bus.z_out, 0);
    drain();

    // extremes
    obs_q.delete();
    drive(4095, 2046, 3798, 2685, 0, 0, 1'b1);    step();
    drive(0, 0, 0, 0, 2357, 4158, 1'b1);          step();
    drive(4095, 0, 0, 0, 0, 4095, 1'b1);          step();
    drain();
    chk("ext_count", obs_q.size(), 3);
    if (obs_q.size() == 3) begin
      chk("ext_max_pos", obs_q[0], 3382);
      chk("ext_max_neg", obs_q[1], 2727);
      chk("ext_cancel", obs_q[2], 0);
    end

    // streaming, one per cycle
    base_res = n_res;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rand_vec(1'b1);
      step();
    end
    chk("stream_rate", n_res - base_res, 998);
    bus.in_valid = 1'b0;
    step();
    step();
    chk("stream_total", n_res - base_res, 1000);
    chk("stream_empty", exp_q.size(), 0);

    // backpressure with two in flight
    obs_q.delete();
    base_acc = n_acc;
    rand_vec(1'b1); step();
    rand_vec(1'b1); step();
    held = exp_q[0];
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_vec(1'b1);
      step();
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_z_stable", bus.z_out, held);
    end
    drain();
    chk("bp_accepted", n_acc - base_acc, 2);
    chk("bp_results", obs_q.size(), 2);

    // random valid/ready toggling
    base_acc = n_acc;
    base_res = n_res;
    for (int i = 0; i < 10000; i++) begin
      rand_vec(1'($urandom_range(1)));
      bus.out_ready = ($urandom_range(3) != 0);
      step();
    end
    drain();
    chk("rand_count", n_res - base_res, n_acc - base_acc);

    // reset while stalled with a valid output
    bus.out_ready = 1'b0;
    rand_vec(1'b1); step();
    bus.in_valid = 1'b0;
    step(); step();
    chk("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    chk("mid_rst_z", bus.z_out, 0);
    exp_q.delete();
    obs_q.delete();
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 1'b1);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_count", obs_q.size(), 1);
    if (obs_q.size() == 1) chk("post_rst_z", obs_q[0], 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
